sort4_ctrl: RTL
===============

SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width in bits.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1: in_data holds a valid word.
REQ-005 Port in_ready, output, 1: the block accepts a word this cycle.
REQ-006 Port in_data, input, W: unsigned input word.
REQ-007 Port descend, input, 1: sort order; 0 = ascending, 1 = descending; sampled with the first word of a set.
REQ-008 Port out_valid, output, 1: out_data holds a sorted word.
REQ-009 Port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-010 Port out_data, output, W: sorted word.
REQ-011 Port out_last, output, 1: high with the 4th output word of a set.
REQ-012 Port swap_cnt, output, 3: number of swaps performed for the current set.
REQ-013 Port busy, output, 1: high in SORT and DRAIN.

Function
REQ-014 The block SHALL sort a set of exactly 4 words using one shared unsigned W-bit magnitude comparator (lt/gt/eq).
REQ-015 The FSM SHALL have three states: LOAD, SORT and DRAIN.
REQ-016 LOAD: in_ready=1; each in_valid&&in_ready handshake writes in_data into mem[idx] and increments idx (0..3); the handshake at idx=0 latches descend into ord.
REQ-017 On the handshake at idx=3 the block SHALL go to SORT, clear idx, and clear swap_cnt.
REQ-018 SORT: in_ready=0; exactly one compare per cycle over 6 fixed cycles, on pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
REQ-019 For the pair (a,b) = (mem[i], mem[i+1]): swap when ord=0 and a>b, or when ord=1 and a<b.
REQ-020 Each swap SHALL increment swap_cnt (maximum 6, no wrap).
REQ-021 Equal words SHALL never swap, so the sort is stable.
REQ-022 After the 6th compare the block SHALL go to DRAIN; out_valid SHALL rise in the cycle after that compare edge, 7 edges after the 4th input handshake.
REQ-023 DRAIN: out_valid=1 and out_data=mem[idx]; each out_valid&&out_ready handshake increments idx.
REQ-024 out_last SHALL be 1 when idx=3; the handshake at idx=3 SHALL return the FSM to LOAD with idx=0.
REQ-025 With out_valid=1 and out_ready=0, out_data, out_last and swap_cnt SHALL hold stable.
REQ-026 swap_cnt SHALL hold its value through DRAIN and LOAD until the next SORT entry.
REQ-027 in_valid outside LOAD SHALL be ignored; in_data is not captured and state does not change.
REQ-028 out_ready outside DRAIN SHALL be ignored.
REQ-029 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-030 While rst_n=0, regardless of clk, the block SHALL hold: state=LOAD, idx=0, ord=0, swap_cnt=0, mem all zero.
REQ-031 Reset values of the outputs SHALL be: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-032 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the partial set; the first set after release starts at idx=0.
REQ-033 in_ready MAY be high in the first cycle after rst_n rises.

Verification
REQ-034 Load 4,3,2,1 with descend=0 -> output 1,2,3,4, out_last on the 4th word, swap_cnt=6, first out_valid 7 edges after the 4th input handshake.
REQ-035 Load 1,2,3,4 with descend=1 -> output 4,3,2,1, swap_cnt=6; the same set with descend=0 -> output 1,2,3,4, swap_cnt=0.
REQ-036 Load 5,5,5,5, then 0x00,0xFF,0x00,0xFF with descend=0 -> output 5,5,5,5 with swap_cnt=0, then 0x00,0x00,0xFF,0xFF with swap_cnt=1.
REQ-037 Hold out_ready=0 for 5 cycles on each word in DRAIN -> out_data stable, no word lost or duplicated; in_valid pulses during SORT/DRAIN are ignored.
REQ-038 Assert rst_n=0 at the 3rd SORT cycle -> outputs take their reset values immediately; the next set 9,7,8,6 -> output 6,7,8,9, swap_cnt=5.
REQ-039 Drive back-to-back sets with in_valid=1 and out_ready=1 held high -> each set takes 4+6+4 cycles, and in_ready rises the cycle after the out_last handshake.

Source files
------------

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads four unsigned words, sorts them in six fixed compare
// steps through one shared comparator, then streams them out in order.
module sort4_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         descend,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [2:0]   swap_cnt,
  output logic         busy
);

  localparam int unsigned NW    = 4;
  localparam int unsigned IDXW  = 2;
  localparam int unsigned STPW  = 3;
  localparam int unsigned SWPW  = 3;
  localparam logic [STPW-1:0] LAST_STEP = STPW'(5);
  localparam logic [SWPW-1:0] MAX_SWAP  = SWPW'(6);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NW - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t          state_q, state_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic [STPW-1:0] step_q, step_n;
  logic            ord_q, ord_n;
  logic [SWPW-1:0] swap_q, swap_n;
  logic [W-1:0]    mem_q [NW];
  logic [W-1:0]    mem_n [NW];

  logic [IDXW-1:0] pi, pj;
  logic [W-1:0]    a, b;
  logic            lt, gt, do_swap;

  // Shared comparator on the pair selected by the current sort step
  always_comb begin
    case (step_q)
      STPW'(0): pi = IDXW'(0);
      STPW'(1): pi = IDXW'(1);
      STPW'(2): pi = IDXW'(2);
      STPW'(3): pi = IDXW'(0);
      STPW'(4): pi = IDXW'(1);
      default:  pi = IDXW'(0);
    endcase
    pj      = pi + IDXW'(1);
    a       = mem_q[pi];
    b       = mem_q[pj];
    lt      = (a < b);
    gt      = (a > b);
    do_swap = ord_q ? lt : gt;
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    step_n  = step_q;
    ord_n   = ord_q;
    swap_n  = swap_q;
    mem_n   = mem_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_n[idx_q] = in_data;
          if (idx_q == IDXW'(0)) ord_n = descend;
          if (idx_q == LAST_IDX) begin
            state_n = SORT;
            idx_n   = IDXW'(0);
            step_n  = STPW'(0);
            swap_n  = SWPW'(0);
          end else begin
            idx_n = idx_q + IDXW'(1);
          end
        end
      end
      SORT: begin
        if (do_swap) begin
          mem_n[pi] = b;
          mem_n[pj] = a;
          if (swap_q < MAX_SWAP) swap_n = swap_q + SWPW'(1);
        end
        if (step_q == LAST_STEP) begin
          state_n = DRAIN;
          step_n  = STPW'(0);
        end else begin
          step_n = step_q + STPW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_n = LOAD;
            idx_n   = IDXW'(0);
          end else begin
            idx_n = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_n = LOAD;
        idx_n   = IDXW'(0);
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      step_q    <= '0;
      ord_q     <= 1'b0;
      swap_q    <= '0;
      for (int i = 0; i < NW; i++) mem_q[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      step_q    <= step_n;
      ord_q     <= ord_n;
      swap_q    <= swap_n;
      for (int i = 0; i < NW; i++) mem_q[i] <= mem_n[i];
      in_ready  <= (state_n == LOAD);
      out_valid <= (state_n == DRAIN);
      out_last  <= (state_n == DRAIN) && (idx_n == LAST_IDX);
      busy      <= (state_n != LOAD);
      out_data  <= (state_n == DRAIN) ? mem_n[idx_n] : '0;
    end
  end

  assign swap_cnt = swap_q;

endmodule
